// File: rtl/add_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : add_share_arb
//  Purpose  : Round-robin share of one 16-bit saturating CLA adder between two
//             requesters, with an operand stage and an optional result stage.
//  Revision : 1.0 - initial release
// ============================================================================
module add_share_arb #(
    parameter logic RESET_PTR = 1'b0,
    parameter logic PIPE_OUT  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        req0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        cin0,
    input  logic        req1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic        cin1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid,
    output logic        rid,
    output logic [15:0] rsum,
    output logic        rcout,
    output logic        rovfl
);

    logic        r_ptr;
    logic        r_s1_v;
    logic        r_s1_id;
    logic        r_s1_cin;
    logic [15:0] r_s1_a;
    logic [15:0] r_s1_b;

    logic        w_acc;
    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [15:0] w_c;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_gc;
    logic [15:0] w_raw;
    logic        w_ovfl;
    logic [15:0] w_sum;

    // A grant always implies the matching request, so a grant is an accept.
    assign gnt0  = ~rst & ~stall & req0 & (~req1 | ~r_ptr);
    assign gnt1  = ~rst & ~stall & req1 & (~req0 |  r_ptr);
    assign w_acc = gnt0 | gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= RESET_PTR;
            r_s1_v   <= 1'b0;
            r_s1_id  <= 1'b0;
            r_s1_cin <= 1'b0;
            r_s1_a   <= 16'h0000;
            r_s1_b   <= 16'h0000;
        end else if (!stall) begin
            r_s1_v <= w_acc;
            if (w_acc) begin
                r_ptr    <= ~gnt1;
                r_s1_id  <= gnt1;
                r_s1_a   <= gnt1 ? a1   : a0;
                r_s1_b   <= gnt1 ? b1   : b0;
                r_s1_cin <= gnt1 ? cin1 : cin0;
            end
        end
    end

    assign w_p = r_s1_a ^ r_s1_b;
    assign w_g = r_s1_a & r_s1_b;

    // Second-level lookahead across the four 4-bit groups.
    assign w_gc[0] = r_s1_cin;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & r_s1_cin);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (&w_gp[1:0] & r_s1_cin);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (&w_gp[2:1] & w_gg[0])
                   | (&w_gp[2:0] & r_s1_cin);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (&w_gp[3:2] & w_gg[1])
                   | (&w_gp[3:1] & w_gg[0]) | (&w_gp[3:0] & r_s1_cin);

    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int B = 4 * k;
        assign w_c[B]   = w_gc[k];
        assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[k]);
        assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (&w_p[B+1:B] & w_gc[k]);
        assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (&w_p[B+2:B+1] & w_g[B])
                        | (&w_p[B+2:B] & w_gc[k]);
        assign w_gg[k]  = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (&w_p[B+3:B+2] & w_g[B+1])
                        | (&w_p[B+3:B+1] & w_g[B]);
        assign w_gp[k]  = &w_p[B+3:B];
    end

    assign w_raw  = w_p ^ w_c;
    // Overflow only when like-signed operands produce a result of the other sign.
    assign w_ovfl = (r_s1_a[15] == r_s1_b[15]) & (w_raw[15] != r_s1_a[15]);
    assign w_sum  = w_ovfl ? (r_s1_a[15] ? 16'h8000 : 16'h7fff) : w_raw;

    if (PIPE_OUT) begin : g_pipe
        logic        r_s2_v;
        logic        r_s2_id;
        logic [15:0] r_s2_sum;
        logic        r_s2_cout;
        logic        r_s2_ovfl;

        // Payload loads only with a valid op so outputs hold between results.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s2_v    <= 1'b0;
                r_s2_id   <= 1'b0;
                r_s2_sum  <= 16'h0000;
                r_s2_cout <= 1'b0;
                r_s2_ovfl <= 1'b0;
            end else if (!stall) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_id   <= r_s1_id;
                    r_s2_sum  <= w_sum;
                    r_s2_cout <= w_gc[4];
                    r_s2_ovfl <= w_ovfl;
                end
            end
        end

        assign rvalid = r_s2_v;
        assign rid    = r_s2_id;
        assign rsum   = r_s2_sum;
        assign rcout  = r_s2_cout;
        assign rovfl  = r_s2_ovfl;
    end else begin : g_comb
        assign rvalid = r_s1_v;
        assign rid    = r_s1_id;
        assign rsum   = w_sum;
        assign rcout  = w_gc[4];
        assign rovfl  = w_ovfl;
    end

endmodule
`default_nettype wire

// File: doc/add_share_arb.md
Name: add_share_arb

Overview:
- Shares one 16-bit saturating carry-lookahead adder between two requesters, e.g. the ALU add path (req 0) and the PC/branch-target path (req 1).
- Round-robin arbitration with a req/gnt handshake.
- Two-stage pipeline: operand register, then result register. Accepts one operation per cycle.
- A stall input freezes the whole block for hazard/memory stalls.

Parameters:
- RESET_PTR, 0: requester holding priority after reset (0 or 1).
- PIPE_OUT, 1: 1 = result register present (latency 2); 0 = result driven combinationally from the operand register (latency 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freeze: no grant, all registers hold.
- req0  in  1  requester 0 wants an add.
- a0, b0  in  16 each  requester 0 operands (two's complement).
- cin0  in  1  requester 0 carry-in.
- req1, a1, b1, cin1  in  1/16/16/1  same fields for requester 1.
- gnt0, gnt1  out  1 each  combinational grant; accept = req & gnt at the clock edge.
- rvalid  out  1  result valid this cycle (one-cycle pulse per accepted op).
- rid  out  1  requester that owns the result.
- rsum  out  16  saturated sum.
- rcout  out  1  carry-out of bit 15.
- rovfl  out  1  signed overflow (saturation applied).

Behaviour:
- Reset (async, immediate):
  - ptr = RESET_PTR.
  - Stage-1 and stage-2 valid bits = 0.
  - rvalid = 0, rid = 0, rsum = 0x0000, rcout = 0, rovfl = 0.
  - gnt0 = gnt1 = 0 while rst is high.
- Grant (combinational):
  - stall=1: gnt0 = gnt1 = 0.
  - Only one req high: that requester is granted.
  - Both high: requester ptr is granted.
  - At most one gnt high in any cycle.
- Pointer: on each accept, ptr <= ~(granted id). No accept: ptr holds.
- Handshake: the requester holds req and stable operands until it samples gnt=1 at a clock edge. A request is never dropped or duplicated.
- Stage 1 (S1): on accept, capture {id, a, b, cin} and set s1_v=1; with no accept, s1_v <= 0.
- Adder: evaluated from S1 registers.
  - raw = a + b + cin, 16-bit; cout = carry out of bit 15.
  - a[15]=b[15]=0 and raw[15]=1: sum = 0x7FFF, ovfl = 1.
  - a[15]=b[15]=1 and raw[15]=0: sum = 0x8000, ovfl = 1.
  - Otherwise sum = raw, ovfl = 0.
  - Mixed-sign operands never overflow.
  - cout always reflects the raw (unsaturated) carry.
- Stage 2 (PIPE_OUT=1): S2 <= {s1_v, id, sum, cout, ovfl} each un-stalled edge.
  - Outputs are driven from S2; latency accept→rvalid = 2 edges.
- PIPE_OUT=0: outputs driven from S1 plus the adder; latency 1.
- Outputs while rvalid=0: rsum/rcout/rovfl/rid hold their last value (not cleared).
- Stall:
  - All registers, including ptr, hold.
  - rvalid stays at its registered value and is not re-pulsed.
  - No new accept while stalled.
  - When stall drops, the pipeline resumes with no lost or duplicated result.
- Throughput: back-to-back accepts allowed; with both requesting continuously, grants alternate 0,1,0,1…
- Reset mid-operation: in-flight ops are discarded; requesters re-issue after reset.

Test Plan:
- Saturate positive: req0, a0=0x7000, b0=0x2000, cin0=0 → gnt0 same cycle; 2 edges later rvalid=1, rid=0, rsum=0x7FFF, rovfl=1, rcout=0.
- Saturate negative plus carry: req1, a1=0x8000, b1=0x8000 → rsum=0x8000, rovfl=1, rcout=1. Then a1=0xFFFF, b1=0x0001 → rsum=0x0000, rcout=1, rovfl=0.
- Round-robin: RESET_PTR=0, req0=req1=1 held for 4 cycles with distinct operands → grants 0,1,0,1; rvalid on 4 consecutive cycles, rid 0,1,0,1, each rsum matching its operands.
- Stall: accept 0x0003+0x0004 (cin=1), then raise stall for 3 cycles → no grants; result 0x0008 appears exactly once, after stall drops, with the latency counted in un-stalled edges.
- Async reset: assert rst between clock edges with two ops in flight → outputs zero immediately; no rvalid after rst drops; ptr = RESET_PTR.
- PIPE_OUT=0 build: req0, 0x1234+0x1111 → rvalid=1, rsum=0x2345 one edge after accept.
